// File: rtl/speaker_ctl.sv
// Stereo DAC serializer: mclk/sck/lrck dividers and a left-justified, MSB-first 16-bit sdin stream.
// Latency: samples captured at the frame wrap edge; left MSB on sdin at once, right MSB 256 clks later.
// Backpressure: none; free-running 512-clk frame, inputs are sampled only at the wrap edge.
module speaker_ctl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] audio_left,
    input  logic [15:0] audio_right,
    input  logic        mute,
    output logic        audio_mclk,
    output logic        audio_sck,
    output logic        audio_lrck,
    output logic        audio_sdin,
    output logic        sample_tick
);

    logic [8:0]  r_cnt;
    logic [15:0] r_sh;
    logic [15:0] r_hold_r;
    logic        r_mclk;
    logic        r_sck;
    logic        r_lrck;
    logic        r_tick;

    logic [8:0]  w_cnt_nxt;
    logic        w_slot_edge;
    logic        w_wrap;
    logic        w_mid;

    assign w_cnt_nxt   = r_cnt + 9'd1;
    // Slot boundary: cnt[3:0] 15->0, the sck falling edge.
    assign w_slot_edge = (r_cnt[3:0] == 4'hF);
    assign w_wrap      = (r_cnt == 9'd511);
    assign w_mid       = (r_cnt == 9'd255);

    // Frame counter plus clock outputs registered from the next count, so each
    // clock pin is its own flop yet always equals the matching counter bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 9'd0;
            r_mclk <= 1'b0;
            r_sck  <= 1'b0;
            r_lrck <= 1'b1;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_mclk <= w_cnt_nxt[1];
            r_sck  <= w_cnt_nxt[3];
            r_lrck <= ~w_cnt_nxt[8];
            // Pulses only for cnt==0 reached by a wrap, i.e. when samples were taken.
            r_tick <= w_wrap;
        end
    end

    // Serial shifter: load left and latch right on wrap, load right at mid-frame,
    // otherwise shift one bit per slot boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh     <= 16'h0000;
            r_hold_r <= 16'h0000;
        end else if (w_wrap) begin
            r_sh     <= mute ? 16'h0000 : audio_left;
            r_hold_r <= mute ? 16'h0000 : audio_right;
        end else if (w_mid) begin
            r_sh     <= r_hold_r;
        end else if (w_slot_edge) begin
            r_sh     <= {r_sh[14:0], 1'b0};
        end
    end

    assign audio_mclk  = r_mclk;
    assign audio_sck   = r_sck;
    assign audio_lrck  = r_lrck;
    assign audio_sdin  = r_sh[15];
    assign sample_tick = r_tick;

endmodule

// File: tb/tb_speaker_ctl.sv
// Bench for speaker_ctl: frame-level model of the expected stream plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_speaker_ctl;

    logic        clk;
    logic        rst_n;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        mute;
    logic        audio_mclk;
    logic        audio_sck;
    logic        audio_lrck;
    logic        audio_sdin;
    logic        sample_tick;

    int checks = 0;
    int fails  = 0;

    // Model state: clocks since reset release, and the words of the current frame.
    int          m_k = 0;
    logic [15:0] m_l = 16'h0000;
    logic [15:0] m_r = 16'h0000;

    speaker_ctl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .mute        (mute),
        .audio_mclk  (audio_mclk),
        .audio_sck   (audio_sck),
        .audio_lrck  (audio_lrck),
        .audio_sdin  (audio_sdin),
        .sample_tick (sample_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Model advance: a frame is the 512 clks after a wrap; its words are the
    // (mute-gated) inputs present on the wrap edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0;
            m_l = 16'h0000;
            m_r = 16'h0000;
        end else begin
            if (m_k % 512 == 511) begin
                m_l = mute ? 16'h0000 : audio_left;
                m_r = mute ? 16'h0000 : audio_right;
            end
            m_k = m_k + 1;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_mclk", {31'd0, audio_mclk}, 32'd0);
            chk("rst_sck",  {31'd0, audio_sck},  32'd0);
            chk("rst_lrck", {31'd0, audio_lrck}, 32'd1);
            chk("rst_sdin", {31'd0, audio_sdin}, 32'd0);
            chk("rst_tick", {31'd0, sample_tick}, 32'd0);
        end else begin
            int c, f, slot;
            logic [15:0] w;
            logic        e_sd;
            c    = m_k % 512;
            f    = m_k / 512;
            slot = (c / 16) % 16;
            w    = (c < 256) ? m_l : m_r;
            e_sd = (f == 0) ? 1'b0 : w[15 - slot];
            chk("mclk", {31'd0, audio_mclk}, {31'd0, ((c / 2) % 2) == 1});
            chk("sck",  {31'd0, audio_sck},  {31'd0, ((c / 8) % 2) == 1});
            chk("lrck", {31'd0, audio_lrck}, {31'd0, c < 256});
            chk("sdin", {31'd0, audio_sdin}, {31'd0, e_sd});
            chk("tick", {31'd0, sample_tick}, {31'd0, (c == 0) && (f > 0)});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_cnt(input int target);
        int guard = 0;
        while ((m_k % 512 != target) && guard < 1100) begin
            step(1);
            guard++;
        end
        if (m_k % 512 != target) begin
            fails++;
            $display("FAIL wait_cnt timeout target=%0d actual=%0d", target, m_k % 512);
        end
    endtask

    // Capture one full frame of sdin at the sck rising-edge positions.
    // act: 1 = switch left to 16'hB000, 2 = drop mute; performed at cnt == act_at.
    task automatic get_frame(input int act_at, input int act,
                             output logic [15:0] l, output logic [15:0] r);
        l = 16'h0000;
        r = 16'h0000;
        wait_cnt(0);
        for (int i = 0; i < 512; i++) begin
            int c;
            c = m_k % 512;
            if (c % 16 == 8) begin
                if (c < 256) l[15 - (c / 16) % 16] = audio_sdin;
                else         r[15 - (c / 16) % 16] = audio_sdin;
            end
            if (c == act_at) begin
                if (act == 1) audio_left = 16'hB000;
                if (act == 2) mute = 1'b0;
            end
            step(1);
        end
    endtask

    initial begin
        logic [15:0] l, r;
        int n_tick, n_mclk, n_sck, n_lrck, last_tick;
        logic p_mclk, p_sck, p_lrck;

        rst_n       = 1'b0;
        audio_left  = 16'hB000;
        audio_right = 16'h5FFF;
        mute        = 1'b0;
        step(5);
        chk("reset_lrck_hi", {31'd0, audio_lrck}, 32'd1);
        chk("reset_tick_lo", {31'd0, sample_tick}, 32'd0);
        rst_n = 1'b1;

        // First frame after release is silent, the next carries the samples.
        get_frame(-1, 0, l, r);
        chk("frame0_left",  {16'd0, l}, 32'h0000);
        chk("frame0_right", {16'd0, r}, 32'h0000);
        get_frame(-1, 0, l, r);
        chk("frame1_left",  {16'd0, l}, 32'hB000);
        chk("frame1_right", {16'd0, r}, 32'h5FFF);

        // 4096-clk free run: edge counts and tick spacing.
        wait_cnt(0);
        n_tick = 0; n_mclk = 0; n_sck = 0; n_lrck = 0; last_tick = -1;
        p_mclk = audio_mclk; p_sck = audio_sck; p_lrck = audio_lrck;
        for (int i = 0; i <= 4096; i++) begin
            if (i > 0) begin
                if (!p_mclk && audio_mclk) n_mclk++;
                if (!p_sck  && audio_sck)  n_sck++;
                if (!p_lrck && audio_lrck) n_lrck++;
            end
            if (i < 4096 && sample_tick) begin
                if (last_tick >= 0) chk("tick_spacing", i - last_tick, 512);
                last_tick = i;
                n_tick++;
            end
            p_mclk = audio_mclk; p_sck = audio_sck; p_lrck = audio_lrck;
            if (i < 4096) step(1);
        end
        chk("tick_count", n_tick, 8);
        chk("mclk_rises", n_mclk, 1024);
        chk("sck_rises",  n_sck,  256);
        chk("lrck_rises", n_lrck, 8);

        // Mid-frame input change waits for the next frame.
        audio_left = 16'h5FFF;
        get_frame(-1, 0, l, r);
        chk("pre_change_left", {16'd0, l}, 32'hB000);
        get_frame(100, 1, l, r);
        chk("change_cur_left", {16'd0, l}, 32'h5FFF);
        get_frame(-1, 0, l, r);
        chk("change_next_left", {16'd0, l}, 32'hB000);

        // Mute at the wrap holds the whole frame silent even if released early.
        audio_left  = 16'h7FFF;
        audio_right = 16'h8000;
        mute        = 1'b1;
        get_frame(-1, 0, l, r);
        chk("premute_left", {16'd0, l}, 32'hB000);
        get_frame(10, 2, l, r);
        chk("muted_left",  {16'd0, l}, 32'h0000);
        chk("muted_right", {16'd0, r}, 32'h0000);
        get_frame(-1, 0, l, r);
        chk("unmuted_left",  {16'd0, l}, 32'h7FFF);
        chk("unmuted_right", {16'd0, r}, 32'h8000);

        // Reset in the middle of a frame.
        audio_left  = 16'h1234;
        audio_right = 16'hABCD;
        wait_cnt(300);
        rst_n = 1'b0;
        #1;
        chk("midrst_mclk", {31'd0, audio_mclk}, 32'd0);
        chk("midrst_sck",  {31'd0, audio_sck},  32'd0);
        chk("midrst_lrck", {31'd0, audio_lrck}, 32'd1);
        chk("midrst_sdin", {31'd0, audio_sdin}, 32'd0);
        chk("midrst_tick", {31'd0, sample_tick}, 32'd0);
        step(3);
        rst_n = 1'b1;
        get_frame(-1, 0, l, r);
        chk("postrst_f0_left",  {16'd0, l}, 32'h0000);
        chk("postrst_f0_right", {16'd0, r}, 32'h0000);
        get_frame(-1, 0, l, r);
        chk("postrst_f1_left",  {16'd0, l}, 32'h1234);
        chk("postrst_f1_right", {16'd0, r}, 32'hABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
